// File: rtl/joltage_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// joltage_accumulator_pkg
// Shared constants and types for the joltage accumulator slice.
//   DATA_WIDTH : default width of line values and the running sum
//   DIGIT_W    : width of one BCD digit
//   BASE       : radix used when folding the digit stack into a binary value
//   state_t    : control FSM states of the top level
// -----------------------------------------------------------------------------
package joltage_accumulator_pkg;

   localparam int DATA_WIDTH = 64;
   localparam int DIGIT_W    = 4;
   localparam int BASE       = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2,
      EMIT  = 2'd3
   } state_t;

endpackage

// File: rtl/joltage_accumulator_stack.sv
// -----------------------------------------------------------------------------
// greedy_digit_stack
// Monotonic stack keeping the best k digits of a line in arrival order.
// For each pushed digit the pop target is found in one cycle with a bank of
// parallel "entry < digit" comparators; the digit is written at the pop target
// when that position is below k_eff, otherwise it is discarded.
//
// Ports
//   clock, reset   : clock, synchronous active-high reset (clears depth only)
//   push           : a digit is presented this cycle
//   first          : the digit opens a new line; the stack is treated as empty
//   digit          : sanitised digit 0..9
//   floor_pos      : lowest position that may be popped to
//   k_eff          : number of digits to keep for this line
//   rd_idx         : read index used while draining
//   rd_digit       : entry at rd_idx
//   depth          : current number of valid entries
//   depth_next     : value depth takes at the next clock edge
// -----------------------------------------------------------------------------
module greedy_digit_stack
   import joltage_accumulator_pkg::*;
#(
   parameter int MAX_K = 12,
   parameter int K_W   = $clog2(MAX_K + 1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               push,
   input  logic               first,
   input  logic [DIGIT_W-1:0] digit,
   input  logic [K_W-1:0]     floor_pos,
   input  logic [K_W-1:0]     k_eff,
   input  logic [K_W-1:0]     rd_idx,
   output logic [DIGIT_W-1:0] rd_digit,
   output logic [K_W-1:0]     depth,
   output logic [K_W-1:0]     depth_next
);

   logic [DIGIT_W-1:0] entry [MAX_K];
   logic [K_W-1:0]     cur_depth;
   logic [K_W-1:0]     pop_pos;
   logic [MAX_K:0]     suffix_ok;
   logic               accept;

   always_comb begin
      cur_depth = first ? '0 : depth;

      // suffix_ok[j]: every live entry at j..depth-1 is strictly below the
      // incoming digit, so popping down to j is legal. Equal entries stop it.
      suffix_ok = '1;
      for (int i = MAX_K - 1; i >= 0; i--) begin
         if (K_W'(i) < cur_depth) begin
            suffix_ok[i] = suffix_ok[i + 1] & (entry[i] < digit);
         end else begin
            suffix_ok[i] = 1'b1;
         end
      end

      // Smallest legal j in [floor_pos, depth]. If the floor sits above the
      // depth (line shorter than k) nothing is popped and the digit appends.
      pop_pos = cur_depth;
      for (int j = MAX_K; j >= 0; j--) begin
         if ((K_W'(j) >= floor_pos) && (K_W'(j) <= cur_depth) && suffix_ok[j]) begin
            pop_pos = K_W'(j);
         end
      end

      accept = push && (pop_pos < k_eff);

      if (accept) begin
         depth_next = pop_pos + 1'b1;
      end else if (push) begin
         depth_next = cur_depth;
      end else begin
         depth_next = depth;
      end

      rd_digit = (rd_idx < K_W'(MAX_K)) ? entry[rd_idx] : '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         depth <= '0;
      end else begin
         depth <= depth_next;
      end
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         entry[pop_pos] <= digit;
      end
   end

endmodule

// File: rtl/joltage_accumulator.sv
// -----------------------------------------------------------------------------
// joltage_accumulator
// Streaming per-line maximum k-digit subsequence engine with a running sum.
// Digits arrive one per cycle on a valid/ready handshake; a greedy stack keeps
// the best k digits, the stack is folded into a binary value at end of line
// (one digit per cycle), and each line value is added into a running total.
//
// Ports
//   clock, reset : clock, synchronous active-high reset
//   cfg_k        : digits to select, sampled on the first digit of a line
//   line_len     : declared line length, sampled on the first digit
//   in_valid     : digit present
//   in_ready     : digit accepted this cycle (IDLE and FILL only)
//   in_digit     : BCD digit, values above 9 are taken as 0
//   in_last      : final digit of the line
//   line_valid   : one-cycle pulse while the line result is being committed
//   line_value   : value of the last completed line
//   sum_value    : running sum of line values, wraps modulo 2^ACC_W
//   line_count   : number of completed lines
//   err          : sticky error flag, cleared only by reset
// -----------------------------------------------------------------------------
module joltage_accumulator
   import joltage_accumulator_pkg::*;
#(
   parameter int MAX_K    = 12,
   parameter int MAX_LINE = 128,
   parameter int ACC_W    = DATA_WIDTH
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [$clog2(MAX_K+1)-1:0]    cfg_k,
   input  logic [$clog2(MAX_LINE+1)-1:0] line_len,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DIGIT_W-1:0]            in_digit,
   input  logic                          in_last,
   output logic                          line_valid,
   output logic [ACC_W-1:0]              line_value,
   output logic [ACC_W-1:0]              sum_value,
   output logic [15:0]                   line_count,
   output logic                          err
);

   localparam int K_W = $clog2(MAX_K + 1);
   localparam int L_W = $clog2(MAX_LINE + 1);
   localparam logic [K_W-1:0] K_MAX = K_W'(MAX_K);

   function automatic logic [K_W-1:0] clamp_k(input logic [K_W-1:0] k);
      return (k > K_MAX) ? K_MAX : k;
   endfunction

   function automatic logic [DIGIT_W-1:0] sanitize_digit(input logic [DIGIT_W-1:0] d);
      return (d > DIGIT_W'(9)) ? '0 : d;
   endfunction

   function automatic logic [ACC_W-1:0] times_base(input logic [ACC_W-1:0] a);
      return a * ACC_W'(BASE);
   endfunction

   state_t             state;
   state_t             state_next;

   logic [K_W-1:0]     k_reg;
   logic [L_W-1:0]     len_reg;
   logic [L_W-1:0]     idx_reg;
   logic [K_W-1:0]     drain_idx;
   logic [ACC_W-1:0]   acc;

   logic               fire;
   logic               first;
   logic [K_W-1:0]     k_cur;
   logic [L_W-1:0]     len_cur;
   logic [L_W-1:0]     idx_cur;
   logic [L_W:0]       len_w;
   logic [L_W:0]       idx_w;
   logic [L_W:0]       k_w;
   logic [L_W:0]       remaining;
   logic [K_W-1:0]     floor_pos;
   logic               last_pos;
   logic               line_end;
   logic               early_last;
   logic               forced_end;
   logic               bad_digit;
   logic               cfg_err;
   logic               err_hit;
   logic [DIGIT_W-1:0] digit_clean;
   logic [DIGIT_W-1:0] drain_digit;
   logic [K_W-1:0]     depth;
   logic [K_W-1:0]     depth_next;

   greedy_digit_stack #(
      .MAX_K (MAX_K),
      .K_W   (K_W)
   ) u_stack (
      .clock      (clock),
      .reset      (reset),
      .push       (fire),
      .first      (first),
      .digit      (digit_clean),
      .floor_pos  (floor_pos),
      .k_eff      (k_cur),
      .rd_idx     (drain_idx),
      .rd_digit   (drain_digit),
      .depth      (depth),
      .depth_next (depth_next)
   );

   always_comb begin
      in_ready   = (state == IDLE) || (state == FILL);
      line_valid = (state == EMIT);
      fire       = in_valid && in_ready;
      first      = (state == IDLE);

      // On the opening digit the line parameters come straight from the ports;
      // afterwards the values latched at that handshake are used.
      k_cur      = first ? clamp_k(cfg_k) : k_reg;
      len_cur    = first ? line_len : len_reg;
      idx_cur    = first ? '0 : idx_reg;

      len_w      = {1'b0, len_cur};
      idx_w      = {1'b0, idx_cur};
      k_w        = (L_W + 1)'(k_cur);

      // Digits still to come including this one, and the lowest position we
      // may pop to while still being able to fill k_eff slots.
      remaining  = (idx_w < len_w) ? (len_w - idx_w) : '0;
      floor_pos  = (k_w > remaining) ? K_W'(k_w - remaining) : '0;

      last_pos   = (idx_w + 1'b1) >= len_w;
      line_end   = in_last || last_pos;
      early_last = in_last && ((idx_w + 1'b1) != len_w);
      forced_end = !in_last && last_pos;

      bad_digit   = in_digit > DIGIT_W'(9);
      digit_clean = sanitize_digit(in_digit);
      cfg_err     = first && ((cfg_k > K_MAX) || (cfg_k == '0) ||
                              (line_len < L_W'(clamp_k(cfg_k))));
      err_hit     = fire && (bad_digit || early_last || forced_end || cfg_err);
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, FILL: begin
            if (fire) begin
               if (!line_end) begin
                  state_next = FILL;
               end else if (depth_next != '0) begin
                  state_next = DRAIN;
               end else begin
                  state_next = EMIT;
               end
            end
         end
         DRAIN: begin
            if ((drain_idx + 1'b1) == depth) begin
               state_next = EMIT;
            end
         end
         EMIT: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         k_reg      <= '0;
         len_reg    <= '0;
         idx_reg    <= '0;
         drain_idx  <= '0;
         line_value <= '0;
         sum_value  <= '0;
         line_count <= '0;
         err        <= 1'b0;
      end else begin
         state <= state_next;
         if (err_hit) begin
            err <= 1'b1;
         end
         if (fire && first) begin
            k_reg   <= k_cur;
            len_reg <= len_cur;
         end
         if (fire) begin
            idx_reg <= idx_cur + 1'b1;
         end
         if (state == DRAIN) begin
            drain_idx <= drain_idx + 1'b1;
         end else begin
            drain_idx <= '0;
         end
         if (state == EMIT) begin
            line_value <= acc;
            sum_value  <= sum_value + acc;
            line_count <= line_count + 16'd1;
         end
      end
   end

   // Accumulator: cleared whenever a line is being collected, so a reset in
   // the middle of a drain can never leak a partial value into the next line.
   always_ff @(posedge clock) begin
      if (state == DRAIN) begin
         acc <= times_base(acc) + ACC_W'(drain_digit);
      end else if (state != EMIT) begin
         acc <= '0;
      end
   end

endmodule

// File: tb/tb_joltage_accumulator.sv
module tb_joltage_accumulator;

   localparam int MAX_K    = 12;
   localparam int MAX_LINE = 128;
   localparam int ACC_W    = 64;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic [3:0]       cfg_k = '0;
   logic [7:0]       line_len = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [3:0]       in_digit = '0;
   logic             in_last = 1'b0;
   logic             line_valid;
   logic [ACC_W-1:0] line_value;
   logic [ACC_W-1:0] sum_value;
   logic [15:0]      line_count;
   logic             err;

   int               n_cmp = 0;
   int               n_bad = 0;
   int               line_buf [MAX_LINE];
   int               line_n = 0;
   logic [63:0]      model_sum = '0;
   int               model_cnt = 0;

   joltage_accumulator #(
      .MAX_K    (MAX_K),
      .MAX_LINE (MAX_LINE),
      .ACC_W    (ACC_W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .cfg_k      (cfg_k),
      .line_len   (line_len),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_digit   (in_digit),
      .in_last    (in_last),
      .line_valid (line_valid),
      .line_value (line_value),
      .sum_value  (sum_value),
      .line_count (line_count),
      .err        (err)
   );

   always #5 clock = ~clock;

   initial begin
      #3000000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      in_last  = 1'b0;
      reset    = 1'b1;
      tick();
      tick();
      reset     = 1'b0;
      model_sum = '0;
      model_cnt = 0;
   endtask

   task automatic load_str(input string s);
      line_n = s.len();
      for (int i = 0; i < line_n; i++) line_buf[i] = int'(s[i]) - 48;
   endtask

   task automatic load_rand(input int n);
      line_n = n;
      for (int i = 0; i < n; i++) line_buf[i] = int'($urandom_range(0, 9));
   endtask

   // Largest k-digit subsequence: for each output slot take the leftmost
   // maximum inside the window that still leaves room for the later slots.
   function automatic logic [63:0] model_value(input int k);
      int ku, start, bi, best, d;
      logic [63:0] v;
      ku = (k > MAX_K) ? MAX_K : k;
      if (ku > line_n) ku = line_n;
      v = '0;
      start = 0;
      for (int pos = 0; pos < ku; pos++) begin
         best = -1;
         bi   = start;
         for (int i = start; i <= line_n - (ku - pos); i++) begin
            d = (line_buf[i] > 9) ? 0 : line_buf[i];
            if (d > best) begin
               best = d;
               bi   = i;
            end
         end
         v = v * 64'd10 + 64'(best);
         start = bi + 1;
      end
      return v;
   endfunction

   task automatic run_line(input int k, input int len_decl, input bit gap, input bit wait_done,
                           input logic [63:0] exp_val, input int exp_depth, input string tag);
      int cnt, lowcnt;
      bit saw;
      for (int i = 0; i < line_n; i++) begin
         in_valid = 1'b1;
         in_digit = 4'(line_buf[i]);
         in_last  = (i == line_n - 1);
         if (i == 0) begin
            cfg_k    = 4'(k);
            line_len = 8'(len_decl);
         end
         cnt = 0;
         while (!in_ready && cnt < 40) begin
            tick();
            cnt++;
         end
         if (cnt >= 40) check({tag, "_ready_timeout"}, 64'(in_ready), 64'd1);
         tick();
         in_valid = 1'b0;
         in_last  = 1'b0;
         if (i == 0) begin
            cfg_k    = 4'($urandom_range(0, 15));
            line_len = 8'($urandom_range(0, 255));
         end
         if (gap && i < line_n - 1) tick();
      end
      if (wait_done) begin
         lowcnt = 0;
         saw    = 1'b0;
         while (!in_ready && lowcnt < 100) begin
            if (line_valid) saw = 1'b1;
            tick();
            lowcnt++;
         end
         model_sum = model_sum + exp_val;
         model_cnt++;
         check({tag, "_busy"},  64'(lowcnt), 64'(exp_depth + 1));
         check({tag, "_pulse"}, 64'(saw), 64'd1);
         check({tag, "_value"}, line_value, exp_val);
         check({tag, "_sum"},   sum_value, model_sum);
         check({tag, "_count"}, 64'(line_count), 64'(model_cnt));
      end
   endtask

   string       lines [4] = '{"987654321111111", "811111111111119",
                              "234234234234278", "818181911112111"};
   logic [63:0] exp2  [4] = '{64'd98, 64'd89, 64'd78, 64'd92};
   logic [63:0] exp12 [4] = '{64'd987654321111, 64'd811111111119,
                              64'd434234234278, 64'd888911112111};

   initial begin
      int n, k;
      bit g;
      logic [63:0] ev;

      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      check("rst_ready", 64'(in_ready), 64'd1);
      check("rst_lvalid", 64'(line_valid), 64'd0);
      check("rst_value", line_value, 64'd0);
      check("rst_sum", sum_value, 64'd0);
      check("rst_count", 64'(line_count), 64'd0);
      check("rst_err", 64'(err), 64'd0);

      for (int i = 0; i < 4; i++) begin
         load_str(lines[i]);
         run_line(2, 15, 1'b0, 1'b1, exp2[i], 2, "k2");
      end
      check("k2_total", sum_value, 64'd357);
      check("k2_lines", 64'(line_count), 64'd4);

      do_reset();
      for (int i = 0; i < 4; i++) begin
         load_str(lines[i]);
         run_line(12, 15, 1'b0, 1'b1, exp12[i], 12, "k12");
      end
      check("k12_total", sum_value, 64'd3121910778619);
      check("k12_err", 64'(err), 64'd0);

      do_reset();
      for (int i = 0; i < 4; i++) begin
         k = (i % 2 == 1) ? 12 : 2;
         load_str(lines[i]);
         run_line(k, 15, 1'b1, 1'b1, (k == 2) ? exp2[i] : exp12[i], k, "alt_gap");
      end

      for (int t = 0; t < 10; t++) begin
         n = int'($urandom_range(1, 40));
         k = int'($urandom_range(1, 12));
         if (k > n) k = n;
         g = 1'($urandom_range(0, 1));
         load_rand(n);
         ev = model_value(k);
         run_line(k, n, g, 1'b1, ev, k, "rand");
      end
      check("rand_err", 64'(err), 64'd0);

      load_rand(20);
      ev = model_value(12);
      run_line(15, 20, 1'b0, 1'b1, ev, 12, "k15");
      check("k15_err", 64'(err), 64'd1);

      do_reset();
      check("err_cleared", 64'(err), 64'd0);
      load_str("55");
      run_line(3, 4, 1'b0, 1'b1, 64'd55, 2, "early");
      check("early_err", 64'(err), 64'd1);

      do_reset();
      line_n = 3;
      line_buf[0] = 9;
      line_buf[1] = 10;
      line_buf[2] = 5;
      run_line(2, 3, 1'b0, 1'b1, 64'd95, 2, "bad_digit");
      check("bad_digit_err", 64'(err), 64'd1);

      do_reset();
      load_rand(6);
      ev = model_value(4);
      run_line(4, 6, 1'b0, 1'b1, ev, 4, "pre_drain");
      load_rand(20);
      run_line(12, 20, 1'b0, 1'b0, 64'd0, 12, "cut");
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_sum = '0;
      model_cnt = 0;
      check("mid_rst_ready", 64'(in_ready), 64'd1);
      check("mid_rst_lvalid", 64'(line_valid), 64'd0);
      check("mid_rst_value", line_value, 64'd0);
      check("mid_rst_sum", sum_value, 64'd0);
      check("mid_rst_count", 64'(line_count), 64'd0);
      load_rand(17);
      ev = model_value(5);
      run_line(5, 17, 1'b0, 1'b1, ev, 5, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
